// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder.
// Accepts one word request per valid/ready handshake, waits out a programmable
// number of wait states, performs the access and returns a one-cycle response.
//
// Handshake semantics: a request is accepted on a rising edge where
// req_valid && req_ready. req_ready is high only while idle. A request
// presented while busy is ignored, not queued, so the requester must keep
// req_valid high until it sees req_ready. resp_valid is a single-cycle strobe
// with no back-pressure. resp_rdata and resp_err are qualified by resp_valid
// and read as zero at all other times.
//
// Timing: a request accepted on edge N produces resp_valid in the cycle after
// edge N+WAIT_STATES+1. The WAIT state therefore lasts WAIT_STATES+1 cycles,
// which also covers WAIT_STATES=0. The next request can be accepted in the first
// IDLE cycle after RESP.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          do_access;
  logic          addr_err;
  logic [AW-1:0] idx;

  assign accept   = req_valid && (state_q == ST_IDLE);
  assign idx      = addr_q[AW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // Next-state, wait counter and registered response data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_CNT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = ST_RESP;
          do_access = 1'b1;
          err_d     = addr_err;
          rdata_d   = (!we_q && !addr_err) ? mem_q[idx] : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State, counter and response registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latch the request at acceptance; inputs are ignored until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // RAM write on the edge entering RESP; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !addr_err) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES=2 and WAIT_STATES=0)
// share one stimulus stream and are each tracked by an edge-count model.
module tb_dmem_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        ready0, rv0, err0, busy0;
  logic [31:0] rd0;
  logic [1:0]  st0;
  logic        ready1, rv1, err1, busy1;
  logic [31:0] rd1;
  logic [1:0]  st1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .busy(busy0),
    .dbg_state(st0)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1),
    .dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int resp0_cnt = 0;
  int resp1_cnt = 0;
  logic [32:0] exp_q[$];

  // Reference model: a request accepted on edge e responds after edge e+ws+1
  // and the next acceptance is possible on edge e+ws+3.
  int          free_e[2];
  int          due_e[2];
  bit          pend_v[2];
  bit          pend_we[2];
  bit          pend_err[2];
  logic [5:0]  pend_idx[2];
  logic [31:0] pend_wd[2];
  logic [31:0] mem_m[2][64];
  bit          known[2][64];

  function automatic int ws_of(int i);
    return (i == 0) ? WS0 : WS1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int i, input logic a_ready, input logic a_rv,
                            input logic a_err, input logic a_busy,
                            input logic [31:0] a_rd, input logic [1:0] a_st);
    bit          resp_now = 1'b0;
    bit          e_err    = 1'b0;
    bit          rd_known = 1'b1;
    logic [31:0] e_rd     = 32'd0;
    bit          e_ready;
    if (!rst_n) begin
      pend_v[i] = 1'b0;
      free_e[i] = 0;
    end else begin
      if (pend_v[i] && cyc == due_e[i]) begin
        resp_now  = 1'b1;
        pend_v[i] = 1'b0;
        e_err     = pend_err[i];
        if (!pend_err[i]) begin
          if (pend_we[i]) begin
            mem_m[i][pend_idx[i]] = pend_wd[i];
            known[i][pend_idx[i]] = 1'b1;
          end else begin
            e_rd     = mem_m[i][pend_idx[i]];
            rd_known = known[i][pend_idx[i]];
          end
        end
      end
      if (req_valid && cyc >= free_e[i]) begin
        pend_v[i]   = 1'b1;
        pend_we[i]  = req_we;
        pend_wd[i]  = req_wdata;
        pend_idx[i] = req_addr[7:2];
        pend_err[i] = (req_addr[1:0] != 2'b00) || (req_addr[31:8] != 24'd0);
        due_e[i]    = cyc + ws_of(i) + 1;
        free_e[i]   = cyc + ws_of(i) + 3;
      end
    end
    e_ready = (cyc + 1 >= free_e[i]);
    chk($sformatf("u%0d.req_ready", i), a_ready, e_ready);
    chk($sformatf("u%0d.busy", i), a_busy, !e_ready);
    chk($sformatf("u%0d.dbg_state_busy", i), (a_st != 2'd0), !e_ready);
    chk($sformatf("u%0d.resp_valid", i), a_rv, resp_now);
    chk($sformatf("u%0d.resp_err", i), a_err, e_err);
    if (rd_known) chk($sformatf("u%0d.resp_rdata", i), a_rd, e_rd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    model_step(0, ready0, rv0, err0, busy0, rd0, st0);
    model_step(1, ready1, rv1, err1, busy1, rd1, st1);
    if (rv0) resp0_cnt++;
    if (rv1) resp1_cnt++;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy0 || busy1) && t < 40) begin
      step();
      t++;
    end
    if (busy0 || busy1) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: busy0=%0b busy1=%0b after %0d edges", busy0, busy1, t);
    end
  endtask

  // Issue one request to both idle instances and collect both responses.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] r0, output logic e0, output int lat0,
                        output logic [31:0] r1, output logic e1, output int lat1);
    int acc;
    int t;
    bit got0 = 1'b0;
    bit got1 = 1'b0;
    r0 = 32'd0; e0 = 1'b0; lat0 = -1;
    r1 = 32'd0; e1 = 1'b0; lat1 = -1;
    wait_idle();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    step();
    acc = cyc;
    req_valid = 1'b0;
    t = 0;
    while (!(got0 && got1) && t < 20) begin
      step();
      t++;
      if (rv0 && !got0) begin got0 = 1'b1; r0 = rd0; e0 = err0; lat0 = cyc - acc; end
      if (rv1 && !got1) begin got1 = 1'b1; r1 = rd1; e1 = err1; lat1 = cyc - acc; end
    end
    if (!(got0 && got1)) begin
      n_chk++;
      n_fail++;
      $display("FAIL do_req_timeout: got0=%0b got1=%0b addr %h", got0, got1, addr);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r0, r1;
    logic        e0, e1;
    logic [32:0] exp_v;
    int          lat0, lat1;
    int          base;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0000_0001};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'h2222_2222, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0000};

    for (int i = 0; i < 2; i++) begin
      free_e[i] = 0; due_e[i] = -1; pend_v[i] = 1'b0;
      for (int j = 0; j < 64; j++) begin known[i][j] = 1'b0; mem_m[i][j] = 32'd0; end
    end

    // Reset with req_valid held high: ready, idle, no response throughout.
    rst_n = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("first_accept_after_release.u0", busy0, 1'b1);
    chk("first_accept_after_release.u1", busy1, 1'b1);
    req_valid = 1'b0;
    wait_idle();

    // Table vectors: contents, error flags and latency per instance.
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back({vecs[k].exp_err, vecs[k].exp_rd});
      do_req(vecs[k].we, vecs[k].addr, vecs[k].wdata, r0, e0, lat0, r1, e1, lat1);
      exp_v = exp_q.pop_front();
      chk($sformatf("vec%0d.u0.rdata", k), r0, exp_v[31:0]);
      chk($sformatf("vec%0d.u0.err", k), e0, exp_v[32]);
      chk($sformatf("vec%0d.u1.rdata", k), r1, exp_v[31:0]);
      chk($sformatf("vec%0d.u1.err", k), e1, exp_v[32]);
      chk($sformatf("vec%0d.u0.latency", k), lat0, 3);
      chk($sformatf("vec%0d.u1.latency", k), lat1, 1);
    end

    // Inputs change and req_valid pulses while busy: latched request wins.
    wait_idle();
    base = resp0_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hA5A5_A5A5;
    step();
    chk("busy_seq.accepted", busy0, 1'b1);
    req_we = 1'b0; req_addr = 32'h34; req_wdata = 32'h5A5A_5A5A;
    step();
    step();
    req_valid = 1'b0;
    repeat (8) step();
    chk("busy_seq.single_response", resp0_cnt - base, 1);
    do_req(1'b0, 32'h30, 32'd0, r0, e0, lat0, r1, e1, lat1);
    chk("busy_seq.u0.rdata", r0, 32'hA5A5_A5A5);
    chk("busy_seq.u1.rdata", r1, 32'hA5A5_A5A5);

    // Reset during WAIT of a store: no response, store not committed.
    wait_idle();
    base = resp0_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h7777_7777;
    step();
    chk("rst_seq.accepted", busy0, 1'b1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("rst_seq.no_response", resp0_cnt - base, 0);
    do_req(1'b0, 32'h20, 32'd0, r0, e0, lat0, r1, e1, lat1);
    chk("rst_seq.u0.rdata", r0, 32'h0000_0001);
    chk("rst_seq.u1.rdata", r1, 32'h0000_0001);
    chk("rst_seq.u1.latency", lat1, 1);

    // Random traffic with occasional resets, checked by the model every edge.
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      req_wdata = $urandom;
      if (sel < 7)       req_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel == 7) req_addr = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 8) req_addr = {8'($urandom_range(1, 255)), 24'($urandom)};
      else               req_addr = 32'h0000_00FC;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    step();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
